// File: rtl/axis_packet_fifo_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axis_packet_fifo_buffer_pkg
// Purpose  : Shared AXI-Stream types and width constants for the multi-channel
//            packet FIFO buffer. Stream beats are carried as packed structs.
//            axis_mosi_t holds the beat plus TVALID. axis_miso_t holds TREADY.
// Ports    : n/a (package)
// Revision : 1.0 - initial release
// ============================================================================
package axis_packet_fifo_buffer_pkg;

    localparam int C_DATA_WIDTH = 32;
    localparam int C_STRB_WIDTH = C_DATA_WIDTH / 8;
    localparam int C_ID_WIDTH   = 4;
    localparam int C_DEST_WIDTH = 4;
    localparam int C_USER_WIDTH = 4;

    // One stream beat, stored in the FIFO exactly as received.
    typedef struct packed {
        logic [C_DATA_WIDTH-1:0] tdata;
        logic [C_STRB_WIDTH-1:0] tstrb;
        logic [C_STRB_WIDTH-1:0] tkeep;
        logic                    tlast;
        logic [C_ID_WIDTH-1:0]   tid;
        logic [C_DEST_WIDTH-1:0] tdest;
        logic [C_USER_WIDTH-1:0] tuser;
    } axis_data_t;

    typedef struct packed {
        axis_data_t data;
        logic       tvalid;
    } axis_mosi_t;

    typedef struct packed {
        logic tready;
    } axis_miso_t;

    // Width of a counter able to hold the values 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage : axis_packet_fifo_buffer_pkg
`default_nettype wire

// File: rtl/axis_packet_fifo_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : axis_packet_fifo_buffer_if
// Purpose  : Bundle of CHANNEL_NUMBER AXI-Stream links (beat + TVALID forward,
//            TREADY backward).
//            master modport : drives mosi, receives miso
//            slave  modport : receives mosi, drives miso
// Revision : 1.0 - initial release
// ============================================================================
interface axis_packet_fifo_buffer_if #(
    parameter int CHANNEL_NUMBER = 8
);
    import axis_packet_fifo_buffer_pkg::*;

    axis_mosi_t [CHANNEL_NUMBER-1:0] mosi;
    axis_miso_t [CHANNEL_NUMBER-1:0] miso;

    modport master (output mosi, input  miso);
    modport slave  (input  mosi, output miso);

endinterface : axis_packet_fifo_buffer_if
`default_nettype wire

// File: rtl/axis_packet_fifo_buffer_channel_fifo.sv
`default_nettype none
// ============================================================================
// Module   : axis_channel_fifo
// Purpose  : Single-channel first-word-fall-through AXI-Stream FIFO with an
//            optional store-and-forward packet mode. It also provides the
//            occupancy, almost-full and high-water-mark outputs.
// Ports    : clk, rst          - clock, asynchronous active-high reset
//            i_in_mosi / o_in_miso   - upstream beat+TVALID / TREADY
//            o_out_mosi / i_out_miso - downstream beat+TVALID / TREADY
//            o_level, o_almost_full, o_hwm - occupancy monitors
//            i_hwm_clear       - synchronous high-water-mark clear
// Revision : 1.0 - initial release
// ============================================================================
module axis_channel_fifo
    import axis_packet_fifo_buffer_pkg::*;
#(
    parameter int BUFFER_LENGTH     = 8,
    parameter int PACKET_MODE       = 0,
    parameter int ALMOST_FULL_LEVEL = BUFFER_LENGTH - 2,
    localparam int LW               = $clog2(BUFFER_LENGTH + 1)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire axis_mosi_t    i_in_mosi,
    output axis_miso_t         o_in_miso,
    output axis_mosi_t         o_out_mosi,
    input  wire axis_miso_t    i_out_miso,
    output logic [LW-1:0]      o_level,
    output logic               o_almost_full,
    output logic [LW-1:0]      o_hwm,
    input  wire logic          i_hwm_clear
);

    localparam int            PW      = $clog2(BUFFER_LENGTH);
    localparam logic [LW-1:0] c_full  = LW'(BUFFER_LENGTH);
    localparam logic [LW-1:0] c_afull = LW'(ALMOST_FULL_LEVEL);

    axis_data_t    r_mem [BUFFER_LENGTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [LW-1:0] r_count;
    logic [LW-1:0] r_hwm;
    logic          r_tready;

    logic          w_wr;
    logic          w_rd;
    logic          w_valid;
    logic [LW-1:0] w_count_next;
    axis_data_t    w_head;

    assign w_head       = r_mem[r_rptr];
    assign w_wr         = i_in_mosi.tvalid & r_tready;
    assign w_rd         = w_valid & i_out_miso.tready;
    assign w_count_next = r_count + {{(LW-1){1'b0}}, w_wr} - {{(LW-1){1'b0}}, w_rd};

    // Output-valid policy. Both variants depend only on registered state.
    // Therefore TVALID cannot drop until a read has taken place.
    generate
        if (PACKET_MODE != 0) begin : g_packet
            logic [LW-1:0] r_pkt_cnt;
            logic          w_wr_last;
            logic          w_rd_last;

            assign w_wr_last = w_wr & i_in_mosi.data.tlast;
            assign w_rd_last = w_rd & w_head.tlast;

            // Number of complete packets held. It is bounded by r_count, so it cannot overflow.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_pkt_cnt <= '0;
                end else if (w_wr_last && !w_rd_last) begin
                    r_pkt_cnt <= r_pkt_cnt + LW'(1);
                end else if (!w_wr_last && w_rd_last) begin
                    r_pkt_cnt <= r_pkt_cnt - LW'(1);
                end
            end

            // When the buffer is full, a packet longer than the buffer is allowed to flow.
            // Without this, such a packet would deadlock the channel.
            assign w_valid = (r_count != '0) && ((r_pkt_cnt != '0) || (r_count == c_full));
        end else begin : g_cut_through
            assign w_valid = (r_count != '0);
        end
    endgenerate

    // Storage carries no reset; contents are meaningless while r_count is 0.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_in_mosi.data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_hwm    <= '0;
            r_tready <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count  <= w_count_next;
            // TREADY is a register. A slot freed by a read while full opens next cycle.
            r_tready <= (w_count_next < c_full);
            if (i_hwm_clear) begin
                r_hwm <= w_count_next;
            end else if (w_count_next > r_hwm) begin
                r_hwm <= w_count_next;
            end
        end
    end

    assign o_in_miso.tready  = r_tready;
    assign o_out_mosi.data   = w_head;
    assign o_out_mosi.tvalid = w_valid;
    assign o_level           = r_count;
    assign o_almost_full     = (r_count >= c_afull);
    assign o_hwm             = r_hwm;

endmodule : axis_channel_fifo
`default_nettype wire

// File: rtl/axis_packet_fifo_buffer.sv
`default_nettype none
// ============================================================================
// Module   : axis_packet_fifo_buffer
// Purpose  : CHANNEL_NUMBER independent AXI-Stream elastic buffers. Each
//            channel can be cut-through or store-and-forward, selected by
//            PACKET_MODE. Each channel has its own occupancy, almost-full and
//            high-water-mark outputs, which feed the performance monitor.
// Ports    : ACLK, ARESET   - clock, asynchronous active-high reset
//            in_axis        - upstream links (slave side)
//            out_axis       - downstream links (master side)
//            level_o        - per-channel beat count
//            almost_full_o  - per-channel level_o >= ALMOST_FULL_LEVEL
//            hwm_o          - per-channel peak level since reset/clear
//            hwm_clear_i    - synchronous clear of all hwm_o
// Revision : 1.0 - initial release
// ============================================================================
module axis_packet_fifo_buffer
    import axis_packet_fifo_buffer_pkg::*;
#(
    parameter int CHANNEL_NUMBER    = 8,
    parameter int BUFFER_LENGTH     = 8,   // power of two, >= 2
    parameter int PACKET_MODE       = 0,
    parameter int ALMOST_FULL_LEVEL = BUFFER_LENGTH - 2,   // must be > 0
    localparam int LW               = $clog2(BUFFER_LENGTH + 1)
) (
    input  wire logic                         ACLK,
    input  wire logic                         ARESET,
    axis_packet_fifo_buffer_if.slave          in_axis,
    axis_packet_fifo_buffer_if.master         out_axis,
    output logic [CHANNEL_NUMBER-1:0][LW-1:0] level_o,
    output logic [CHANNEL_NUMBER-1:0]         almost_full_o,
    output logic [CHANNEL_NUMBER-1:0][LW-1:0] hwm_o,
    input  wire logic                         hwm_clear_i
);

    generate
        for (genvar g = 0; g < CHANNEL_NUMBER; g++) begin : g_channel
            axis_channel_fifo #(
                .BUFFER_LENGTH     (BUFFER_LENGTH),
                .PACKET_MODE       (PACKET_MODE),
                .ALMOST_FULL_LEVEL (ALMOST_FULL_LEVEL)
            ) u_fifo (
                .clk           (ACLK),
                .rst           (ARESET),
                .i_in_mosi     (in_axis.mosi[g]),
                .o_in_miso     (in_axis.miso[g]),
                .o_out_mosi    (out_axis.mosi[g]),
                .i_out_miso    (out_axis.miso[g]),
                .o_level       (level_o[g]),
                .o_almost_full (almost_full_o[g]),
                .o_hwm         (hwm_o[g]),
                .i_hwm_clear   (hwm_clear_i)
            );
        end
    endgenerate

endmodule : axis_packet_fifo_buffer
`default_nettype wire

// File: tb/tb_axis_packet_fifo_buffer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_axis_packet_fifo_buffer
// Purpose  : Testbench for axis_packet_fifo_buffer. One instance runs in
//            cut-through mode (index 0) and one in packet mode (index 1).
//            A queue-based reference model tracks each channel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_packet_fifo_buffer;
    import axis_packet_fifo_buffer_pkg::*;

    localparam int NCH   = 8;
    localparam int DEPTH = 8;
    localparam int AFL   = DEPTH - 2;
    localparam int LW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    axis_mosi_t [NCH-1:0] drv_in  [2];
    axis_miso_t [NCH-1:0] drv_ord [2];
    logic [1:0]           clr;

    logic [NCH-1:0][LW-1:0] lvl0, lvl1, hwm0, hwm1;
    logic [NCH-1:0]         af0, af1;

    axis_packet_fifo_buffer_if #(.CHANNEL_NUMBER(NCH)) in0 ();
    axis_packet_fifo_buffer_if #(.CHANNEL_NUMBER(NCH)) out0 ();
    axis_packet_fifo_buffer_if #(.CHANNEL_NUMBER(NCH)) in1 ();
    axis_packet_fifo_buffer_if #(.CHANNEL_NUMBER(NCH)) out1 ();

    assign in0.mosi  = drv_in[0];
    assign out0.miso = drv_ord[0];
    assign in1.mosi  = drv_in[1];
    assign out1.miso = drv_ord[1];

    axis_packet_fifo_buffer #(
        .CHANNEL_NUMBER(NCH), .BUFFER_LENGTH(DEPTH), .PACKET_MODE(0), .ALMOST_FULL_LEVEL(AFL)
    ) u_dut_ct (
        .ACLK(clk), .ARESET(rst), .in_axis(in0), .out_axis(out0),
        .level_o(lvl0), .almost_full_o(af0), .hwm_o(hwm0), .hwm_clear_i(clr[0])
    );

    axis_packet_fifo_buffer #(
        .CHANNEL_NUMBER(NCH), .BUFFER_LENGTH(DEPTH), .PACKET_MODE(1), .ALMOST_FULL_LEVEL(AFL)
    ) u_dut_pk (
        .ACLK(clk), .ARESET(rst), .in_axis(in1), .out_axis(out1),
        .level_o(lvl1), .almost_full_o(af1), .hwm_o(hwm1), .hwm_clear_i(clr[1])
    );

    // ---------------- reference model ----------------
    axis_data_t mq    [2][NCH][$];
    bit         m_rdy [2][NCH];
    int         m_hwm [2][NCH];
    int         total = 0;
    int         bad   = 0;

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NCH; c++) begin
                mq[d][c].delete();
                m_rdy[d][c] = 1'b0;
                m_hwm[d][c] = 0;
            end
        end
    endfunction

    // Output is valid when data is present. In packet mode, the buffer must also
    // hold a whole packet or be full.
    function automatic bit exp_valid(input int d, input int c);
        int n;
        bit has_last;
        n = mq[d][c].size();
        has_last = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (mq[d][c][i].tlast) has_last = 1'b1;
        end
        if (n == 0) return 1'b0;
        if (d == 0) return 1'b1;
        return has_last || (n == DEPTH);
    endfunction

    function automatic logic obs_rdy(input int d, input int c);
        return (d == 0) ? in0.miso[c].tready : in1.miso[c].tready;
    endfunction
    function automatic logic obs_vld(input int d, input int c);
        return (d == 0) ? out0.mosi[c].tvalid : out1.mosi[c].tvalid;
    endfunction
    function automatic axis_data_t obs_data(input int d, input int c);
        return (d == 0) ? out0.mosi[c].data : out1.mosi[c].data;
    endfunction
    function automatic logic [LW-1:0] obs_lvl(input int d, input int c);
        return (d == 0) ? lvl0[c] : lvl1[c];
    endfunction
    function automatic logic obs_af(input int d, input int c);
        return (d == 0) ? af0[c] : af1[c];
    endfunction
    function automatic logic [LW-1:0] obs_hwm(input int d, input int c);
        return (d == 0) ? hwm0[c] : hwm1[c];
    endfunction

    function automatic axis_data_t mk_beat(input logic [31:0] v, input logic last);
        axis_data_t b;
        b.tdata = v;
        b.tstrb = 4'($urandom);
        b.tkeep = 4'($urandom);
        b.tlast = last;
        b.tid   = 4'($urandom);
        b.tdest = 4'($urandom);
        b.tuser = 4'($urandom);
        return b;
    endfunction

    task automatic idle();
        for (int d = 0; d < 2; d++) begin
            drv_in[d]  = '0;
            drv_ord[d] = '0;
        end
        clr = 2'b00;
    endtask

    // Advance one clock. Handshakes are decided by the model's own ready/valid.
    task automatic step();
        bit wr [2][NCH];
        bit rd [2][NCH];
        int n;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NCH; c++) begin
                wr[d][c] = drv_in[d][c].tvalid && m_rdy[d][c];
                rd[d][c] = drv_ord[d][c].tready && exp_valid(d, c);
            end
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < NCH; c++) begin
                    if (rd[d][c]) void'(mq[d][c].pop_front());
                    if (wr[d][c]) mq[d][c].push_back(drv_in[d][c].data);
                    n = mq[d][c].size();
                    m_rdy[d][c] = (n < DEPTH);
                    m_hwm[d][c] = clr[d] ? n : ((n > m_hwm[d][c]) ? n : m_hwm[d][c]);
                end
            end
        end
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle();
        #2 rst = 1'b1;
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NCH; c++) begin
                total++;
                if (obs_rdy(d, c) !== 1'b0 || obs_vld(d, c) !== 1'b0 || obs_lvl(d, c) !== '0 ||
                    obs_af(d, c) !== 1'b0 || obs_hwm(d, c) !== '0) begin
                    bad++;
                    $display("FAIL reset_state d%0d ch%0d: rdy=%b vld=%b lvl=%0d af=%b hwm=%0d, required all 0",
                             d, c, obs_rdy(d, c), obs_vld(d, c), obs_lvl(d, c), obs_af(d, c), obs_hwm(d, c));
                end
            end
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NCH; c++) begin
                total++;
                if (obs_rdy(d, c) !== 1'b1) begin
                    bad++;
                    $display("FAIL ready_after_reset d%0d ch%0d: got %b, required 1", d, c, obs_rdy(d, c));
                end
            end
        end
    endtask

    task automatic test_fill_full_drain();
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            drv_in[0][0].data   = mk_beat(32'(i), 1'b0);
            drv_in[0][0].tvalid = 1'b1;
            step();
            total++;
            if (obs_lvl(0, 0) !== LW'(i + 1) || obs_af(0, 0) !== ((i + 1) >= AFL) ||
                obs_rdy(0, 0) !== ((i + 1) < DEPTH)) begin
                bad++;
                $display("FAIL fill beat%0d: lvl=%0d af=%b rdy=%b, required lvl=%0d af=%b rdy=%b",
                         i, obs_lvl(0, 0), obs_af(0, 0), obs_rdy(0, 0), i + 1, (i + 1) >= AFL, (i + 1) < DEPTH);
            end
        end
        total++;
        if (obs_hwm(0, 0) !== LW'(DEPTH)) begin
            bad++;
            $display("FAIL fill_hwm: got %0d, required %0d", obs_hwm(0, 0), DEPTH);
        end
        // Full: a write is offered in the same cycle as the read.
        drv_in[0][0].data    = mk_beat(32'hAA, 1'b0);
        drv_in[0][0].tvalid  = 1'b1;
        drv_ord[0][0].tready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            total++;
            if (obs_vld(0, 0) !== 1'b1 || obs_data(0, 0).tdata !== 32'(k) || obs_data(0, 0) !== mq[0][0][0]) begin
                bad++;
                $display("FAIL drain_order k%0d: vld=%b data=%h, required vld=1 data=%0h",
                         k, obs_vld(0, 0), obs_data(0, 0).tdata, k);
            end
            step();
            if (k == 0) begin
                drv_in[0][0].tvalid = 1'b0;
                total++;
                if (obs_lvl(0, 0) !== LW'(DEPTH - 1) || obs_rdy(0, 0) !== 1'b1) begin
                    bad++;
                    $display("FAIL full_write_read: lvl=%0d rdy=%b, required lvl=%0d rdy=1",
                             obs_lvl(0, 0), obs_rdy(0, 0), DEPTH - 1);
                end
            end
        end
        total++;
        if (obs_lvl(0, 0) !== '0 || obs_vld(0, 0) !== 1'b0 || obs_hwm(0, 0) !== LW'(DEPTH)) begin
            bad++;
            $display("FAIL drained: lvl=%0d vld=%b hwm=%0d, required 0 0 %0d",
                     obs_lvl(0, 0), obs_vld(0, 0), obs_hwm(0, 0), DEPTH);
        end
        idle();
    endtask

    task automatic test_packet_gaps();
        axis_data_t pk [3];
        idle();
        drv_ord[1][1].tready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            pk[b] = mk_beat($urandom, b == 2);
            drv_in[1][1].data   = pk[b];
            drv_in[1][1].tvalid = 1'b1;
            step();
            drv_in[1][1].tvalid = 1'b0;
            for (int g = 0; g < ((b < 2) ? 3 : 0); g++) begin
                total++;
                if (obs_vld(1, 1) !== 1'b0) begin
                    bad++;
                    $display("FAIL pkt_hold beat%0d gap%0d: vld=%b, required 0", b, g, obs_vld(1, 1));
                end
                if (g < 2) step();
            end
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (obs_vld(1, 1) !== 1'b1 || obs_data(1, 1) !== pk[k]) begin
                bad++;
                $display("FAIL pkt_release k%0d: vld=%b data=%h, required vld=1 data=%h",
                         k, obs_vld(1, 1), obs_data(1, 1), pk[k]);
            end
            step();
        end
        total++;
        if (obs_vld(1, 1) !== 1'b0 || obs_lvl(1, 1) !== '0) begin
            bad++;
            $display("FAIL pkt_empty: vld=%b lvl=%0d, required 0 0", obs_vld(1, 1), obs_lvl(1, 1));
        end
        idle();
    endtask

    task automatic test_long_packet();
        axis_data_t ref_pk [10];
        int sent, got, cyc;
        idle();
        for (int i = 0; i < 10; i++) ref_pk[i] = mk_beat(32'h100 + 32'(i), i == 9);
        sent = 0;
        got  = 0;
        cyc  = 0;
        drv_ord[1][2].tready = 1'b1;
        while (got < 10 && cyc < 80) begin
            drv_in[1][2].tvalid = (sent < 10);
            drv_in[1][2].data   = ref_pk[(sent < 10) ? sent : 9];
            total++;
            if (obs_vld(1, 2) !== exp_valid(1, 2) || obs_rdy(1, 2) !== m_rdy[1][2] ||
                obs_lvl(1, 2) !== LW'(mq[1][2].size())) begin
                bad++;
                $display("FAIL long_pkt cyc%0d: vld=%b rdy=%b lvl=%0d, required %b %b %0d",
                         cyc, obs_vld(1, 2), obs_rdy(1, 2), obs_lvl(1, 2), exp_valid(1, 2), m_rdy[1][2], mq[1][2].size());
            end
            if (exp_valid(1, 2)) begin
                total++;
                if (obs_data(1, 2) !== ref_pk[got]) begin
                    bad++;
                    $display("FAIL long_pkt_data beat%0d: got %h, required %h", got, obs_data(1, 2), ref_pk[got]);
                end
                got++;
            end
            if (drv_in[1][2].tvalid && m_rdy[1][2]) sent++;
            step();
            cyc++;
        end
        total++;
        if (got != 10) begin
            bad++;
            $display("FAIL long_pkt_timeout: delivered %0d beats, required 10", got);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        idle();
        for (int k = 0; k < 20; k++) begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < NCH; c++) begin
                    drv_in[d][c].data   = mk_beat({8'(c), 8'(d), 16'(k * (c + 1))}, 1'b1);
                    drv_in[d][c].tvalid = 1'b1;
                    drv_ord[d][c].tready = 1'b1;
                end
            end
            step();
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < NCH; c++) begin
                    total++;
                    if (obs_lvl(d, c) !== LW'(1) || obs_vld(d, c) !== 1'b1 || obs_rdy(d, c) !== 1'b1 ||
                        obs_data(d, c).tdata !== {8'(c), 8'(d), 16'(k * (c + 1))}) begin
                        bad++;
                        $display("FAIL stream k%0d d%0d ch%0d: lvl=%0d vld=%b rdy=%b data=%h, required 1 1 1 %h",
                                 k, d, c, obs_lvl(d, c), obs_vld(d, c), obs_rdy(d, c), obs_data(d, c).tdata,
                                 {8'(c), 8'(d), 16'(k * (c + 1))});
                    end
                end
            end
        end
        // Drain the single remaining beat on every channel.
        for (int d = 0; d < 2; d++) drv_in[d] = '0;
        step();
        idle();
    endtask

    task automatic test_random();
        idle();
        for (int k = 0; k < 300; k++) begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < NCH; c++) begin
                    drv_in[d][c].data    = mk_beat($urandom, ($urandom_range(0, 3) == 0));
                    drv_in[d][c].tvalid  = ($urandom_range(0, 3) != 0);
                    drv_ord[d][c].tready = ($urandom_range(0, 9) < 6);
                end
                clr[d] = ($urandom_range(0, 19) == 0);
            end
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < NCH; c++) begin
                    total++;
                    if (obs_rdy(d, c) !== m_rdy[d][c] || obs_vld(d, c) !== exp_valid(d, c) ||
                        obs_lvl(d, c) !== LW'(mq[d][c].size()) || obs_af(d, c) !== (mq[d][c].size() >= AFL) ||
                        obs_hwm(d, c) !== LW'(m_hwm[d][c]) ||
                        (exp_valid(d, c) && obs_data(d, c) !== mq[d][c][0])) begin
                        bad++;
                        $display("FAIL random k%0d d%0d ch%0d: rdy=%b vld=%b lvl=%0d af=%b hwm=%0d, required %b %b %0d %b %0d (or head data)",
                                 k, d, c, obs_rdy(d, c), obs_vld(d, c), obs_lvl(d, c), obs_af(d, c), obs_hwm(d, c),
                                 m_rdy[d][c], exp_valid(d, c), mq[d][c].size(), mq[d][c].size() >= AFL, m_hwm[d][c]);
                    end
                end
            end
            step();
        end
        idle();
    endtask

    task automatic test_reset_midpacket();
        idle();
        // Start from a known-empty state.
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            for (int d = 0; d < 2; d++) begin
                drv_in[d][3].data   = mk_beat(32'(i), i == 2);
                drv_in[d][3].tvalid = 1'b1;
            end
            step();
        end
        idle();
        total++;
        if (obs_lvl(1, 3) !== LW'(5) || obs_vld(1, 3) !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset: lvl=%0d vld=%b, required 5 1", obs_lvl(1, 3), obs_vld(1, 3));
        end
        #2 rst = 1'b1;
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (obs_rdy(d, 3) !== 1'b0 || obs_vld(d, 3) !== 1'b0 || obs_lvl(d, 3) !== '0 ||
                obs_af(d, 3) !== 1'b0 || obs_hwm(d, 3) !== '0) begin
                bad++;
                $display("FAIL async_reset d%0d: rdy=%b vld=%b lvl=%0d af=%b hwm=%0d, required all 0",
                         d, obs_rdy(d, 3), obs_vld(d, 3), obs_lvl(d, 3), obs_af(d, 3), obs_hwm(d, 3));
            end
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        drv_ord[1][3].tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drv_in[0][3].data   = mk_beat(32'h50 + 32'(i), 1'b0);
            drv_in[0][3].tvalid = 1'b1;
            drv_in[1][3].data   = mk_beat(32'h60 + 32'(i), 1'b0);
            drv_in[1][3].tvalid = (i < 3);
            step();
            total++;
            if (obs_vld(1, 3) !== 1'b0 || obs_lvl(0, 3) !== LW'(i + 1)) begin
                bad++;
                $display("FAIL post_reset i%0d: pk_vld=%b ct_lvl=%0d, required 0 %0d",
                         i, obs_vld(1, 3), obs_lvl(0, 3), i + 1);
            end
        end
        idle();
        drv_ord[0][3].tready = 1'b1;
        step();
        step();
        drv_ord[0][3].tready = 1'b0;
        total++;
        if (obs_lvl(0, 3) !== LW'(3) || obs_hwm(0, 3) !== LW'(5)) begin
            bad++;
            $display("FAIL pre_clear: lvl=%0d hwm=%0d, required 3 5", obs_lvl(0, 3), obs_hwm(0, 3));
        end
        clr = 2'b11;
        step();
        clr = 2'b00;
        total++;
        if (obs_hwm(0, 3) !== LW'(3) || obs_hwm(1, 3) !== LW'(3) || obs_lvl(1, 3) !== LW'(3)) begin
            bad++;
            $display("FAIL hwm_clear: ct_hwm=%0d pk_hwm=%0d pk_lvl=%0d, required 3 3 3",
                     obs_hwm(0, 3), obs_hwm(1, 3), obs_lvl(1, 3));
        end
    endtask

    initial begin
        idle();
        model_reset();
        test_reset();
        test_fill_full_drain();
        test_packet_gaps();
        test_long_packet();
        test_back_to_back();
        test_random();
        test_reset_midpacket();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_axis_packet_fifo_buffer
`default_nettype wire
